// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU load/store path and mem_responder.
// master = CPU side, slave = memory side.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed wait states.
// Word-organised little-endian RAM supporting word/halfword/byte accesses,
// a one-cycle response pulse, and an error flag for misaligned, out-of-range
// or illegal-size requests.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;
    logic        accept;
    logic        enter_resp;

    // Request captured at the accept edge
    logic        hold_write;
    logic [1:0]  hold_size;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;

    // Request as seen at the RESP-entry edge
    logic        cur_write;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    logic             err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rword;
    logic [3:0]       wmask;
    logic [31:0]      wdata_rep;
    logic [31:0]      rdata_ext;

    // RAM is zero at time 0 and deliberately untouched by reset
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    // State and wait counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state logic, handshake and response strobe
    always_comb begin
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        accept         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign enter_resp = (state_next == RESP);

    // Register the request at the accept edge; later bus changes are ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_write <= 1'b0;
            hold_size  <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (accept) begin
            hold_write <= bus.req_write;
            hold_size  <= bus.req_size;
            hold_addr  <= bus.req_addr;
            hold_wdata <= bus.req_wdata;
        end
    end

    // With zero wait states RESP is entered on the accept edge itself, so the
    // access must use the live bus then; otherwise it uses the held request.
    always_comb begin
        if (state == IDLE) begin
            cur_write = bus.req_write;
            cur_size  = bus.req_size;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end else begin
            cur_write = hold_write;
            cur_size  = hold_size;
            cur_addr  = hold_addr;
            cur_wdata = hold_wdata;
        end
    end

    // Error check: illegal size, misalignment, word index beyond the RAM
    always_comb begin
        err = 1'b0;
        case (cur_size)
            2'b00: if (cur_addr[1:0] != 2'b00) err = 1'b1;
            2'b01: if (cur_addr[0]) err = 1'b1;
            2'b10: err = 1'b0;
            default: err = 1'b1;
        endcase
        if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            err = 1'b1;
        end
    end

    assign idx   = cur_addr[IDX_W+1:2];
    assign rword = mem[idx];

    // Byte-lane steering: write mask/replicated data and zero-extended read
    always_comb begin
        wmask     = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        case (cur_size)
            2'b00: begin
                wmask     = '1;
                wdata_rep = cur_wdata;
                rdata_ext = rword;
            end
            2'b01: begin
                wdata_rep = {2{cur_wdata[15:0]}};
                if (cur_addr[1]) begin
                    wmask     = 4'b1100;
                    rdata_ext = {16'h0000, rword[31:16]};
                end else begin
                    wmask     = 4'b0011;
                    rdata_ext = {16'h0000, rword[15:0]};
                end
            end
            2'b10: begin
                wdata_rep = {4{cur_wdata[7:0]}};
                wmask     = 4'b0001 << cur_addr[1:0];
                rdata_ext = {24'h000000, rword[8*cur_addr[1:0] +: 8]};
            end
            default: begin
                wmask = '0;
            end
        endcase
    end

    // RAM write at the RESP-entry edge, addressed lanes only
    always_ff @(posedge clk) begin
        if (enter_resp && cur_write && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // Response data/error registered at the RESP-entry edge and held after
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else if (enter_resp) begin
            bus.resp_err <= err;
            if (err) begin
                bus.resp_rdata <= '0;
            end else if (!cur_write) begin
                bus.resp_rdata <= rdata_ext;
            end
        end
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle CPU's load/store path. It accepts one read or write request at a time over a valid/ready handshake, models a fixed number of wait states, performs word, halfword or byte accesses on an internal word-organised RAM, and returns a single-cycle response with read data and an error flag. It sits between the CPU's address/write-data muxes and the MDR/store-merge logic, replacing the ideal single-cycle memory wherever realistic latency is required.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the RAM; the valid word index is 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 2: wait states inserted between request acceptance and response; legal range 0..15.

- clk  in  1  rising-edge clock; the block uses one clock only.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  the CPU is presenting a request.
- req_ready  out  1  the responder can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 = word, 01 = halfword, 10 = byte, 11 = illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned: byte in [7:0], halfword in [15:0].
- resp_valid  out  1  one-cycle pulse marking the response.
- resp_rdata  out  32  load data, zero-extended and right-aligned; holds its value until the next response.
- resp_err  out  1  the response is an error (misaligned, out of range, or illegal size); valid with resp_valid and held until the next response.

## Operation
- **FSM states:** IDLE, WAIT, RESP. req_ready = (state == IDLE).
- **Accept:** the request is accepted at a rising edge where req_valid && req_ready. At that edge the block registers req_write, req_size, req_addr and req_wdata. Inputs after acceptance are ignored until the block returns to IDLE.
- **IDLE to WAIT/RESP:**
  - On accept with WAIT_CYCLES > 0: go to WAIT and load wait_cnt with WAIT_CYCLES-1.
  - On accept with WAIT_CYCLES = 0: go straight to RESP.
- **WAIT:** decrement wait_cnt each edge. When wait_cnt == 0, go to RESP on the next edge.
- **Edge entering RESP:**
  - Run the error check.
  - If no error and the request is a store, write the RAM.
  - If no error and the request is a load, register the read data into resp_rdata.
  - If there is an error, set resp_rdata = 0 and leave the RAM unchanged.
  - resp_err is registered at the same edge.
- **RESP:** resp_valid = 1 for exactly one cycle, then go to IDLE unconditionally. There is no response backpressure.
- **Error check:** resp_err is 1 if any of the following holds:
  - req_size == 11;
  - word access with addr[1:0] != 0;
  - halfword access with addr[0] != 0;
  - addr[31:2] >= DEPTH_WORDS.
- **Byte lanes (little-endian within a word):** addr[1:0] = 0 selects bits [7:0], and so on up to 3, which selects [31:24]. A halfword at addr[1] = 0 uses [15:0]; at addr[1] = 1 it uses [31:16].
- **Stores:** only the addressed lanes are written; the other bytes of the word are preserved.
- **Loads:** byte and halfword loads are zero-extended. Sign extension belongs to the CPU datapath.
- **RAM contents:** not cleared by reset; initialised to zero at time 0.

## Timing
- **Reset values** (asynchronous on rst = 0): state = IDLE, so req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; wait_cnt = 0.
- **Latency:** with the accept edge numbered E0, the RESP-entry edge is E(WAIT_CYCLES), so resp_valid is high from E(W) to E(W+1).
- **Throughput:**
  - req_ready is low from E0 to E(W+1).
  - The next accept is possible at E(W+2) at the earliest, so the minimum request spacing is W+2 cycles.
  - A request held through the busy period is accepted at the first IDLE edge.
- **Reset mid-transaction:**
  - Asserting rst in WAIT aborts the request; no RAM write and no response occur.
  - Asserting rst during RESP clears resp_valid immediately; a write already committed at the RESP-entry edge persists.
- **req_valid in RESP:** a request raised in RESP is not accepted until IDLE.
- **Read during write:** not possible, because only one transaction is outstanding at a time.

## Test plan
- **Reset:** hold rst = 0 for 3 cycles, release → req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- **Word store then load:** W = 2; store word 0xDEADBEEF at 0x10, then load word from 0x10 → each resp_valid pulse appears exactly 2 edges after its accept edge; the load returns resp_rdata = 0xDEADBEEF with resp_err = 0; req_ready is low for 3 cycles per request.
- **Byte/halfword merge:** word 0x11223344 at 0x20; store byte 0xAA at 0x21; store half 0xBBCC at 0x22; load word 0x20 → 0xBBCCAA44. Load byte from 0x23 → 0x000000BB. Load half from 0x20 → 0x0000AA44.
- **Errors:**
  - Word load at 0x06 → resp_err = 1, resp_rdata = 0.
  - Half store at 0x21 → resp_err = 1, and a later word load at 0x20 is unchanged.
  - Load at 0x400 with DEPTH_WORDS = 256 → resp_err = 1.
  - req_size = 11 → resp_err = 1.
- **W = 0 back-to-back:** req_valid held high for 4 requests → accepts at E0, E2, E4, E6; resp_valid high in the cycles that begin at E0, E2, E4 and E6.
- **Reset abort:** W = 4; store 0x55 to word 0x30; assert rst at edge E2 (before the RESP-entry edge E4) → no resp_valid pulse, req_ready = 1 immediately; a later load of 0x30 returns the old value.
